// File: rtl/spi_slave_reg_ctrl.sv
// Byte-level transaction controller for the low-power SPI slave.
// Splits each chip-select frame into a command byte and data bytes, runs
// register-bank writes/reads over a req/ack handshake, returns read data to
// the slave TX port and requests sleep after a long idle stretch on the bus.
module spi_slave_reg_ctrl #(
    parameter int ADDR_W      = 6,
    parameter int ACK_TIMEOUT = 15,
    parameter int IDLE_CYCLES = 1024
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_SPI_CS_n,
    input  logic              i_RX_DV,
    input  logic [7:0]        i_RX_Byte,
    output logic              o_TX_DV,
    output logic [7:0]        o_TX_Byte,
    output logic              o_Reg_Req,
    output logic              o_Reg_WE,
    output logic [ADDR_W-1:0] o_Reg_Addr,
    output logic [7:0]        o_Reg_WData,
    input  logic              i_Reg_Ack,
    input  logic [7:0]        i_Reg_RData,
    output logic              o_Busy,
    output logic              o_Sleep_Req
);

    localparam int TMR_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_FETCH,
        ST_RD_SHIFT,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic                csMeta_q, csSync_q, csPrev_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ai_q, ai_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          txByte_q, txByte_d;
    logic                txDv_q, txDv_d;
    logic                nack_q, nack_d;
    logic                ovr_q, ovr_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [IDLE_W-1:0]   idleCnt_q, idleCnt_d;

    logic                csFall;
    logic                ackSeen;
    logic                timeoutHit;
    logic [ADDR_W-1:0]   addrNext;

    assign csFall     = csPrev_q & ~csSync_q;
    assign ackSeen    = req_q & i_Reg_Ack;
    assign timeoutHit = req_q & ~i_Reg_Ack & (timer_q == TMR_LAST);
    assign addrNext   = ai_q ? (addr_q + ADDR_W'(1)) : addr_q;

    // Two-flop synchronizer for chip select plus one delayed copy for edge detection; idles deselected.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            csMeta_q <= 1'b1;
            csSync_q <= 1'b1;
            csPrev_q <= 1'b1;
        end else begin
            csMeta_q <= i_SPI_CS_n;
            csSync_q <= csMeta_q;
            csPrev_q <= csSync_q;
        end
    end

    // Next-state and datapath decisions; a chip-select release overrides the per-state outcome at the end.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        ai_d     = ai_q;
        req_d    = req_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        txByte_d = txByte_q;
        txDv_d   = 1'b0;
        nack_d   = nack_q;
        ovr_d    = ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (csFall) begin
                    txByte_d = {nack_q, ovr_q, 6'b000000};
                    txDv_d   = 1'b1;
                    nack_d   = 1'b0;
                    ovr_d    = 1'b0;
                    state_d  = ST_CMD;
                end
            end
            ST_CMD: begin
                if (i_RX_DV) begin
                    addr_d = i_RX_Byte[ADDR_W-1:0];
                    ai_d   = i_RX_Byte[6];
                    if (i_RX_Byte[7]) begin
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        state_d = ST_RD_FETCH;
                    end else begin
                        state_d = ST_WR_DATA;
                    end
                end
            end
            ST_WR_DATA: begin
                if (i_RX_DV) begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    wdata_d = i_RX_Byte;
                    state_d = ST_WR_ACK;
                end
            end
            ST_WR_ACK: begin
                if (i_RX_DV) begin
                    ovr_d = 1'b1;
                end
                if (ackSeen) begin
                    req_d   = 1'b0;
                    addr_d  = addrNext;
                    state_d = ST_WR_DATA;
                end else if (timeoutHit) begin
                    req_d   = 1'b0;
                    nack_d  = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_RD_FETCH: begin
                if (i_RX_DV) begin
                    ovr_d = 1'b1;
                end
                if (ackSeen) begin
                    req_d    = 1'b0;
                    txByte_d = i_Reg_RData;
                    txDv_d   = 1'b1;
                    addr_d   = addrNext;
                    state_d  = ST_RD_SHIFT;
                end else if (timeoutHit) begin
                    req_d   = 1'b0;
                    nack_d  = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_RD_SHIFT: begin
                if (i_RX_DV) begin
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    state_d = ST_RD_FETCH;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DRAIN;
            end
            ST_FINISH: begin
                if (ackSeen) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (timeoutHit) begin
                    req_d   = 1'b0;
                    nack_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (csSync_q && (state_q != ST_IDLE) && (state_q != ST_FINISH)) begin
            if (req_q && !ackSeen && !timeoutHit) begin
                state_d = ST_FINISH;
            end else begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        end
    end

    // Acknowledge timer counts cycles with a request outstanding; idle counter saturates while deselected in IDLE.
    always_comb begin
        timer_d   = req_q ? (timer_q + TMR_W'(1)) : '0;
        idleCnt_d = '0;
        if (csSync_q && (state_q == ST_IDLE)) begin
            idleCnt_d = (idleCnt_q == IDLE_MAX) ? idleCnt_q : (idleCnt_q + IDLE_W'(1));
        end
    end

    // FSM state, transaction registers, sticky flags and counters.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            ai_q      <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            txByte_q  <= '0;
            txDv_q    <= 1'b0;
            nack_q    <= 1'b0;
            ovr_q     <= 1'b0;
            timer_q   <= '0;
            idleCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ai_q      <= ai_d;
            req_q     <= req_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            txByte_q  <= txByte_d;
            txDv_q    <= txDv_d;
            nack_q    <= nack_d;
            ovr_q     <= ovr_d;
            timer_q   <= timer_d;
            idleCnt_q <= idleCnt_d;
        end
    end

    assign o_TX_DV     = txDv_q;
    assign o_TX_Byte   = txByte_q;
    assign o_Reg_Req   = req_q;
    assign o_Reg_WE    = we_q;
    assign o_Reg_Addr  = addr_q;
    assign o_Reg_WData = wdata_q;
    assign o_Busy      = (state_q != ST_IDLE);
    assign o_Sleep_Req = (idleCnt_q == IDLE_MAX);

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Directed bench for spi_slave_reg_ctrl: drives SPI byte events and chip
// select, answers register requests with a delayed ack, logs every completed
// access and every TX load, and compares them with hand-computed values.
module tb_spi_slave_reg_ctrl;

    logic       clk = 1'b0;
    logic       rstN;
    logic       csN;
    logic       rxDv;
    logic [7:0] rxByte;
    logic       txDv;
    logic [7:0] txByte;
    logic       regReq;
    logic       regWe;
    logic [5:0] regAddr;
    logic [7:0] regWData;
    logic       regAck;
    logic [7:0] regRData;
    logic       busy;
    logic       sleepReq;

    int checks = 0;
    int errors = 0;

    int         ackDelay   = 2;
    bit         ackEnable  = 1'b1;
    logic [7:0] bankRData  = 8'h00;
    int         reqAge     = 0;
    int         reqLenLast = 0;

    logic       logWe    [64];
    logic [5:0] logAddr  [64];
    logic [7:0] logWData [64];
    int         logCnt = 0;
    logic [7:0] txLog    [64];
    int         txCnt  = 0;
    int         logBase;
    int         txBase;

    always #5 clk = ~clk;

    spi_slave_reg_ctrl #(
        .ADDR_W      (6),
        .ACK_TIMEOUT (15),
        .IDLE_CYCLES (1024)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rstN),
        .i_SPI_CS_n  (csN),
        .i_RX_DV     (rxDv),
        .i_RX_Byte   (rxByte),
        .o_TX_DV     (txDv),
        .o_TX_Byte   (txByte),
        .o_Reg_Req   (regReq),
        .o_Reg_WE    (regWe),
        .o_Reg_Addr  (regAddr),
        .o_Reg_WData (regWData),
        .i_Reg_Ack   (regAck),
        .i_Reg_RData (regRData),
        .o_Busy      (busy),
        .o_Sleep_Req (sleepReq)
    );

    // Register bank stand-in: acks after ackDelay request cycles and logs the access it completed.
    initial begin
        regAck   = 1'b0;
        regRData = 8'h00;
        forever begin
            @(negedge clk);
            regAck = 1'b0;
            if (regReq === 1'b1) begin
                reqAge++;
                if (ackEnable && reqAge == ackDelay) begin
                    regAck   = 1'b1;
                    regRData = bankRData;
                    if (logCnt < 64) begin
                        logWe[logCnt]    = regWe;
                        logAddr[logCnt]  = regAddr;
                        logWData[logCnt] = regWData;
                    end
                    logCnt++;
                end
            end else if (reqAge != 0) begin
                reqLenLast = reqAge;
                reqAge     = 0;
            end
        end
    end

    // Records every byte loaded into the slave TX port.
    initial begin
        forever begin
            @(negedge clk);
            if (txDv === 1'b1) begin
                if (txCnt < 64) begin
                    txLog[txCnt] = txByte;
                end
                txCnt++;
            end
        end
    end

    // Guards against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] packAcc(input logic we, input logic [5:0] addr, input logic [7:0] data);
        return {17'd0, we, addr, data};
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        @(negedge clk);
        rxDv   = 1'b1;
        rxByte = b;
        @(negedge clk);
        rxDv   = 1'b0;
        waitCycles(gap);
    endtask

    task automatic frameStart();
        @(negedge clk);
        csN = 1'b0;
        waitCycles(5);
    endtask

    task automatic frameEnd();
        @(negedge clk);
        csN = 1'b1;
        waitCycles(6);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence of scenarios.
    initial begin
        rstN   = 1'b0;
        csN    = 1'b1;
        rxDv   = 1'b0;
        rxByte = 8'h00;
        waitCycles(3);
        checkOutput("reset_tx", {23'd0, txDv, txByte}, 32'h0);
        checkOutput("reset_req", {regReq, regWe, regAddr, regWData}, 32'h0);
        checkOutput("reset_busy_sleep", {busy, sleepReq}, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        waitCycles(2);

        $display("[TB] write burst with auto-increment");
        ackDelay = 2;
        logBase  = logCnt;
        txBase   = txCnt;
        frameStart();
        checkOutput("wr_busy_in_frame", busy, 1);
        applyStimulus(8'h45, 8);
        applyStimulus(8'hA1, 8);
        applyStimulus(8'hB2, 8);
        frameEnd();
        checkOutput("wr_tx_count", txCnt - txBase, 1);
        checkOutput("wr_status", txLog[txBase], 8'h00);
        checkOutput("wr_count", logCnt - logBase, 2);
        checkOutput("wr_acc0", packAcc(logWe[logBase], logAddr[logBase], logWData[logBase]), packAcc(1'b1, 6'd5, 8'hA1));
        checkOutput("wr_acc1", packAcc(logWe[logBase+1], logAddr[logBase+1], logWData[logBase+1]), packAcc(1'b1, 6'd6, 8'hB2));
        checkOutput("wr_idle_after", busy, 0);

        // Each dummy byte triggers a prefetch, so cmd + two dummies give three fetches.
        $display("[TB] read without auto-increment");
        bankRData = 8'h5A;
        logBase   = logCnt;
        txBase    = txCnt;
        frameStart();
        applyStimulus(8'h83, 10);
        applyStimulus(8'h00, 10);
        applyStimulus(8'h00, 10);
        frameEnd();
        checkOutput("rd_count", logCnt - logBase, 3);
        checkOutput("rd_acc0", {logWe[logBase], logAddr[logBase]}, {1'b0, 6'd3});
        checkOutput("rd_acc2", {logWe[logBase+2], logAddr[logBase+2]}, {1'b0, 6'd3});
        checkOutput("rd_tx_count", txCnt - txBase, 4);
        checkOutput("rd_tx1", txLog[txBase+1], 8'h5A);
        checkOutput("rd_tx2", txLog[txBase+2], 8'h5A);

        $display("[TB] address wrap");
        logBase = logCnt;
        frameStart();
        applyStimulus(8'h7F, 8);
        applyStimulus(8'h11, 8);
        applyStimulus(8'h22, 8);
        frameEnd();
        checkOutput("wrap_count", logCnt - logBase, 2);
        checkOutput("wrap_acc0", packAcc(logWe[logBase], logAddr[logBase], logWData[logBase]), packAcc(1'b1, 6'd63, 8'h11));
        checkOutput("wrap_acc1", packAcc(logWe[logBase+1], logAddr[logBase+1], logWData[logBase+1]), packAcc(1'b1, 6'd0, 8'h22));

        $display("[TB] acknowledge timeout");
        ackEnable = 1'b0;
        frameStart();
        applyStimulus(8'h81, 20);
        checkOutput("to_req_len", reqLenLast, 15);
        checkOutput("to_req_low", regReq, 0);
        checkOutput("to_drain_busy", busy, 1);
        applyStimulus(8'h55, 4);
        checkOutput("to_drain_no_req", regReq, 0);
        frameEnd();
        checkOutput("to_idle_after", busy, 0);
        ackEnable = 1'b1;
        txBase    = txCnt;
        frameStart();
        frameEnd();
        checkOutput("to_status_nack", txLog[txBase], 8'h80);
        frameStart();
        frameEnd();
        checkOutput("to_status_clear", txLog[txBase+1], 8'h00);

        $display("[TB] overrun");
        ackDelay = 12;
        logBase  = logCnt;
        frameStart();
        applyStimulus(8'h02, 3);
        applyStimulus(8'h33, 3);
        applyStimulus(8'h44, 16);
        frameEnd();
        checkOutput("ovr_count", logCnt - logBase, 1);
        checkOutput("ovr_acc0", packAcc(logWe[logBase], logAddr[logBase], logWData[logBase]), packAcc(1'b1, 6'd2, 8'h33));
        txBase = txCnt;
        frameStart();
        frameEnd();
        checkOutput("ovr_status", txLog[txBase], 8'h40);

        $display("[TB] abort during write, then sleep");
        ackDelay = 10;
        logBase  = logCnt;
        frameStart();
        applyStimulus(8'h09, 1);
        applyStimulus(8'h77, 0);
        @(negedge clk);
        csN = 1'b1;
        waitCycles(4);
        checkOutput("abort_finish_busy", busy, 1);
        checkOutput("abort_req_held", regReq, 1);
        for (int i = 0; i < 60; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        checkOutput("abort_idle", busy, 0);
        checkOutput("abort_acc", packAcc(logWe[logBase], logAddr[logBase], logWData[logBase]), packAcc(1'b1, 6'd9, 8'h77));
        waitCycles(1023);
        checkOutput("sleep_before_limit", sleepReq, 0);
        waitCycles(1);
        checkOutput("sleep_at_limit", sleepReq, 1);
        waitCycles(20);
        checkOutput("sleep_saturated", sleepReq, 1);
        @(negedge clk);
        csN = 1'b0;
        waitCycles(4);
        checkOutput("sleep_cleared", sleepReq, 0);
        frameEnd();

        $display("[TB] reset mid-frame");
        ackDelay = 30;
        logBase  = logCnt;
        ackDelay = 30;
        frameStart();
        applyStimulus(8'h03, 2);
        applyStimulus(8'h66, 3);
        applyStimulus(8'h99, 2);
        checkOutput("rst_req_pending", regReq, 1);
        @(negedge clk);
        rstN = 1'b0;
        csN  = 1'b1;
        #1;
        checkOutput("rst_outputs", {txDv, regReq, busy, sleepReq}, 32'h0);
        waitCycles(3);
        rstN     = 1'b1;
        ackDelay = 2;
        waitCycles(2);
        checkOutput("rst_no_access", logCnt - logBase, 0);
        txBase = txCnt;
        frameStart();
        frameEnd();
        checkOutput("rst_status_clear", txLog[txBase], 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
